// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        WRITE,
        CSUM,
        DONE
    } state_t;

    localparam logic [7:0] CMD_LD_IM = 8'hA5;
    localparam logic [7:0] CMD_LD_DM = 8'h5A;
    localparam logic [7:0] CMD_GO    = 8'h0F;

    localparam int ADDR_WIDTH_DEF = 10;
    localparam int CNT_WIDTH_DEF  = 16;

endpackage

// File: rtl/prog_loader_byte_to_word.sv
// Assembles four bytes, first byte in the low lane, into one 32-bit word.
module byte_to_word (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0] idx;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx  <= 2'd0;
            word <= 32'd0;
        end else if (shift) begin
            idx  <= idx + 2'd1;
            word <= {byte_in, word[31:8]};
        end
    end

    // High while the next shift completes the word.
    assign word_full = (idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: header, payload words into IM/DM, GO releases the core.
// Optional trailing checksum byte enabled by defining PROG_LOADER_CSUM_EN.
//
// state  | meaning
// IDLE   | waiting for a command byte
// CNT_LO | expecting low byte of word count
// CNT_HI | expecting high byte of word count
// DATA   | collecting payload bytes of the current word
// WRITE  | one-cycle write strobe to IM or DM
// CSUM   | expecting XOR checksum of the payload
// DONE   | one-cycle load_done pulse
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  we_im,
    output logic                  we_dm,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [31:0]           din,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  err
);

    state_t               state, state_nxt;
    logic [7:0]           cnt_lo;
    logic [CNT_WIDTH-1:0] words_left;
    logic [CNT_WIDTH-1:0] count_in;
    logic                 tgt_dm;
    logic                 xfer;
    logic                 shift;
    logic                 clr;
    logic                 word_full;
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]           csum;
`endif

    assign byte_ready = !rst && (state inside {IDLE, CNT_LO, CNT_HI, DATA, CSUM});
    assign xfer       = byte_valid && byte_ready;
    assign count_in   = CNT_WIDTH'({byte_data, cnt_lo});

    byte_to_word u_b2w (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .shift     (shift),
        .byte_in   (byte_data),
        .word      (din),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        we_im     = 1'b0;
        we_dm     = 1'b0;
        load_done = 1'b0;
        shift     = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (xfer && (byte_data == CMD_LD_IM || byte_data == CMD_LD_DM)) begin
                    state_nxt = CNT_LO;
                    clr       = 1'b1;
                end
            end
            CNT_LO: if (xfer) state_nxt = CNT_HI;
            CNT_HI: if (xfer) state_nxt = (count_in == '0) ? DONE : DATA;
            DATA: begin
                if (xfer) begin
                    shift = 1'b1;
                    if (word_full) state_nxt = WRITE;
                end
            end
            WRITE: begin
                we_dm = tgt_dm;
                we_im = !tgt_dm;
                if (words_left == CNT_WIDTH'(1)) begin
`ifdef PROG_LOADER_CSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = DATA;
                end
            end
            CSUM: if (xfer) state_nxt = DONE;
            DONE: begin
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            we_im     = 1'b0;
            we_dm     = 1'b0;
            load_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_lo     <= 8'd0;
            words_left <= '0;
            tgt_dm     <= 1'b0;
            addr       <= '0;
            cpu_hold   <= 1'b1;
            err        <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        case (byte_data)
                            CMD_LD_IM, CMD_LD_DM: begin
                                tgt_dm   <= (byte_data == CMD_LD_DM);
                                cpu_hold <= 1'b1;
                                addr     <= '0;
`ifdef PROG_LOADER_CSUM_EN
                                csum     <= 8'd0;
`endif
                            end
                            CMD_GO:  cpu_hold <= 1'b0;
                            default: err      <= 1'b1;
                        endcase
                    end
                end
                CNT_LO: if (xfer) cnt_lo <= byte_data;
                CNT_HI: if (xfer) words_left <= count_in;
`ifdef PROG_LOADER_CSUM_EN
                DATA: if (xfer) csum <= csum ^ byte_data;
                CSUM: if (xfer && byte_data != csum) err <= 1'b1;
`endif
                // Address wraps naturally; oversize loads overwrite from word 0.
                WRITE: begin
                    addr       <= addr + ADDR_WIDTH'(1);
                    words_left <= words_left - CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed header/payload cases plus randomized loads.
module tb_prog_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'd0;
    logic          byte_ready;
    logic          we_im;
    logic          we_dm;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic          cpu_hold;
    logic          load_done;
    logic          err;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we_im      (we_im),
        .we_dm      (we_dm),
        .addr       (addr),
        .din        (din),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .err        (err)
    );

    typedef struct packed {
        logic          dm;
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t         got_q[$];
    wr_t         exp_q[$];
    logic [31:0] pl[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    int          both_hi = 0;
    logic        exp_hold = 1'b1;
    logic        exp_err = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (we_im || we_dm) begin
                wr_t w;
                w.dm = we_dm;
                w.a  = addr;
                w.d  = din;
                got_q.push_back(w);
            end
            if (we_im && we_dm) both_hi++;
            if (load_done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n;
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        byte_valid = 1'b0;
        repeat (g) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", {63'd0, byte_ready}, 64'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic compare_writes();
        int n;
        chk("n_writes", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("wr_target", {63'd0, got_q[i].dm}, {63'd0, exp_q[i].dm});
            chk("wr_addr",   64'(got_q[i].a), 64'(exp_q[i].a));
            chk("wr_data",   64'(got_q[i].d), 64'(exp_q[i].d));
        end
        got_q.delete();
        exp_q.delete();
        chk("we_both_high", both_hi, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready",     {63'd0, byte_ready}, 64'd0);
        chk("rst_cpu_hold",  {63'd0, cpu_hold}, 64'd1);
        chk("rst_err",       {63'd0, err}, 64'd0);
        chk("rst_we",        {62'd0, we_im, we_dm}, 64'd0);
        chk("rst_addr",      64'(addr), 64'd0);
        chk("rst_din",       64'(din), 64'd0);
        chk("rst_load_done", {63'd0, load_done}, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {63'd0, byte_ready}, 64'd1);
        got_q.delete();
        exp_q.delete();
        exp_hold = 1'b1;
        exp_err  = 1'b0;
    endtask

    // Sends a full load of the words in pl and builds the expected write list.
    task automatic run_load(input bit dm, input int max_gap, input bit bad_csum);
        logic [7:0]  x;
        logic [7:0]  by;
        logic [15:0] cnt16;
        int          cnt;
        wr_t         w;
        cnt   = pl.size();
        cnt16 = 16'(cnt);
        x     = 8'd0;
        send_byte(dm ? 8'h5A : 8'hA5, max_gap);
        send_byte(cnt16[7:0], max_gap);
        send_byte(cnt16[15:8], max_gap);
        for (int i = 0; i < cnt; i++) begin
            for (int b = 0; b < 4; b++) begin
                by = pl[i][8*b +: 8];
                x  = x ^ by;
                send_byte(by, max_gap);
            end
            chk("wr_latency", {63'd0, we_im | we_dm}, 64'd1);
            w.dm = dm;
            w.a  = AW'(i % (1 << AW));
            w.d  = pl[i];
            exp_q.push_back(w);
        end
        x = x ^ {7'd0, bad_csum};
        if (cnt == 0) begin
            chk("load_done", {63'd0, load_done}, 64'd1);
        end else begin
`ifdef PROG_LOADER_CSUM_EN
            send_byte(x, max_gap);
            if (bad_csum) exp_err = 1'b1;
`else
            @(negedge clk);
`endif
            chk("load_done", {63'd0, load_done}, 64'd1);
        end
        exp_done++;
        @(negedge clk);
        chk("load_done_cnt", done_cnt, exp_done);
        exp_hold = 1'b1;
        chk("cpu_hold_ld", {63'd0, cpu_hold}, {63'd0, exp_hold});
        chk("err", {63'd0, err}, {63'd0, exp_err});
        compare_writes();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();

        pl.delete();
        pl.push_back(32'h00000513);
        pl.push_back(32'h00100093);
        run_load(1'b0, 0, 1'b0);

        pl.delete();
        pl.push_back(32'hDEADBEEF);
        run_load(1'b1, 0, 1'b0);
        send_byte(8'h0F, 0);
        exp_hold = 1'b0;
        chk("cpu_hold_go", {63'd0, cpu_hold}, 64'd0);

        for (int k = 0; k < 20; k++) begin
            int nw;
            nw = $urandom_range(6, 0);
            pl.delete();
            for (int i = 0; i < nw; i++) pl.push_back($urandom);
            run_load(1'($urandom_range(1, 0)), 3, 1'b0);
            if ($urandom_range(1, 0) == 1) begin
                send_byte(8'h0F, 2);
                exp_hold = 1'b0;
                chk("cpu_hold_go_rand", {63'd0, cpu_hold}, 64'd0);
            end
        end

        pl.delete();
        for (int i = 0; i < 1026; i++) pl.push_back($urandom);
        run_load(1'b1, 0, 1'b0);

        // Reset in the middle of the second word: only word 0 may be written.
        pl.delete();
        for (int i = 0; i < 3; i++) pl.push_back($urandom);
        send_byte(8'hA5, 3);
        send_byte(8'h03, 3);
        send_byte(8'h00, 3);
        for (int b = 0; b < 4; b++) begin
            logic [7:0] by;
            by = pl[0][8*b +: 8];
            send_byte(by, 3);
        end
        begin
            wr_t w;
            w.dm = 1'b0;
            w.a  = '0;
            w.d  = pl[0];
            exp_q.push_back(w);
        end
        for (int b = 0; b < 2; b++) begin
            logic [7:0] by;
            by = pl[1][8*b +: 8];
            send_byte(by, 3);
        end
        compare_writes();
        do_reset();
        chk("writes_after_rst", got_q.size(), 0);
        chk("done_after_rst", done_cnt, exp_done);
        pl.delete();
        pl.push_back(32'hCAFEF00D);
        run_load(1'b0, 1, 1'b0);

        send_byte(8'h77, 0);
        exp_err = 1'b1;
        chk("err_bad_cmd", {63'd0, err}, 64'd1);
        pl.delete();
        run_load(1'b0, 0, 1'b0);
        chk("err_sticky", {63'd0, err}, 64'd1);

`ifdef PROG_LOADER_CSUM_EN
        do_reset();
        pl.delete();
        pl.push_back(32'h44332211);
        run_load(1'b0, 0, 1'b0);
        chk("csum_good_err", {63'd0, err}, 64'd0);
        run_load(1'b0, 0, 1'b1);
        chk("csum_bad_err", {63'd0, err}, 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
